// File: rtl/fp16_add_seq.sv
// fp16_add_seq: multi-cycle IEEE-754 binary16 adder/subtractor.
// Subnormals are flushed to zero; rounding is round-to-nearest, ties-to-even.
module fp16_add_seq (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic        inv
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state, state_nx;
    logic [15:0] ra, rb, big, sml, sp_res, res_nx;
    logic        sp, sp_inv, sgn, op_sub, zero, ovf_nx, inv_nx;
    logic        nan_a, nan_b, inf_a, inf_b, sp_nan, a_ge, up;
    logic [14:0] am, bm, sum;
    logic [4:0]  big_e, dif;
    logic [10:0] big_m, sml_m;
    logic [13:0] x, y, y_al, sml_x, lost, nrm;
    logic [3:0]  lz;
    logic [11:0] rm;
    logic [9:0]  frac;
    logic signed [6:0] e, fe;

    assign busy = (state != IDLE);
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (start ? UNPACK : IDLE) :
                   (state == ROUND) ? IDLE : state_t'(state + 3'd1);
    end

    assign nan_a  = (&ra[14:10]) && (|ra[9:0]);
    assign nan_b  = (&rb[14:10]) && (|rb[9:0]);
    assign inf_a  = (&ra[14:10]) && !(|ra[9:0]);
    assign inf_b  = (&rb[14:10]) && !(|rb[9:0]);
    assign sp_nan = nan_a || nan_b || (inf_a && inf_b && (ra[15] ^ rb[15]));
    // flushed operands compare as magnitude zero
    assign am   = (ra[14:10] == 5'd0) ? 15'd0 : ra[14:0];
    assign bm   = (rb[14:10] == 5'd0) ? 15'd0 : rb[14:0];
    assign a_ge = (am >= bm);
    assign big  = a_ge ? ra : rb;
    assign sml  = a_ge ? rb : ra;

    assign sml_x = {sml_m, 3'b000};
    assign lost  = sml_x & ((14'd1 << dif) - 14'd1);
    assign y_al  = (dif >= 5'd13) ? {13'd0, |sml_m} : (sml_x >> dif) | {13'd0, |lost};

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++)
            if (sum[i]) lz = 4'(13 - i);
    end

    // nrm holds {hidden, 10 fraction bits, guard, round, sticky}
    assign up     = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    assign rm     = {1'b0, nrm[13:3]} + {11'd0, up};
    assign fe     = rm[11] ? e + 7'sd1 : e;
    assign frac   = rm[11] ? rm[10:1] : rm[9:0];
    assign ovf_nx = !sp && !zero && (fe >= 7'sd31);
    assign inv_nx = sp_inv;
    assign res_nx = sp ? sp_res :
                    zero ? {sgn & ~op_sub, 15'd0} :
                    ovf_nx ? {sgn, 15'h7C00} :
                    (fe <= 7'sd0) ? {sgn, 15'd0} : {sgn, fe[4:0], frac};

    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) begin
            ra <= '0; rb <= '0; sp <= 1'b0; sp_inv <= 1'b0; sp_res <= '0;
            sgn <= 1'b0; op_sub <= 1'b0; big_e <= '0; big_m <= '0; sml_m <= '0;
            dif <= '0; x <= '0; y <= '0; sum <= '0; zero <= 1'b0; nrm <= '0; e <= '0;
            done <= 1'b0; result <= '0; ovf <= 1'b0; inv <= 1'b0;
        end else begin
            done <= (state == ROUND);
            if (state == IDLE && start) begin
                ra <= a;
                rb <= {b[15] ^ sub, b[14:0]};
            end
            if (state == UNPACK) begin
                sp     <= sp_nan || inf_a || inf_b;
                sp_inv <= sp_nan;
                sp_res <= sp_nan ? 16'h7E00 : inf_a ? {ra[15], 15'h7C00} : {rb[15], 15'h7C00};
                sgn    <= big[15];
                op_sub <= ra[15] ^ rb[15];
                big_e  <= big[14:10];
                big_m  <= (big[14:10] == 5'd0) ? 11'd0 : {1'b1, big[9:0]};
                sml_m  <= (sml[14:10] == 5'd0) ? 11'd0 : {1'b1, sml[9:0]};
                dif    <= big[14:10] - sml[14:10];
            end
            if (state == ALIGN) begin
                x <= {big_m, 3'b000};
                y <= y_al;
            end
            if (state == ADD)
                sum <= op_sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
            if (state == NORM) begin
                zero <= ~|sum;
                nrm  <= sum[14] ? {sum[14:2], |sum[1:0]} : sum[13:0] << lz;
                e    <= sum[14] ? $signed({2'b00, big_e}) + 7'sd1
                                : $signed({2'b00, big_e}) - $signed({3'b000, lz});
            end
            if (state == ROUND) begin
                result <= res_nx;
                ovf    <= ovf_nx;
                inv    <= inv_nx;
            end
        end
endmodule

// File: doc/fp16_add_seq.md
FP16_ADD_SEQ -- requirements
Module: fp16_add_seq

Interface
Parameters: none. The format is fixed IEEE-754 binary16 (1 sign, 5 exponent, 10 fraction bits, bias 15).
REQ-001 The block SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 The block SHALL have port CLR, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request one operation; sampled only in IDLE.
REQ-004 The block SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b; captured with the operands.
REQ-005 The block SHALL have ports a and b, input, 16 bits each: operands, normally driven from the operand registers.
REQ-006 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid; suitable as the result register load enable.
REQ-008 The block SHALL have port result, output, 16 bits: sum or difference.
REQ-009 The block SHALL have port ovf, output, 1 bit: overflow flag for the last result.
REQ-010 The block SHALL have port inv, output, 1 bit: invalid-operation flag for the last result.

Function
REQ-011 The block SHALL implement the FSM states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND.
- Transitions: IDLE->UNPACK on start=1; every other state advances unconditionally; ROUND->IDLE.
REQ-012 The block SHALL register a, b and sub on the edge that accepts start; later changes on a, b, sub or start SHALL NOT affect the operation in flight.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 A start accepted at edge k SHALL produce result, ovf, inv and done=1 after edge k+5.
- done SHALL stay high for exactly one cycle.
- busy SHALL be high after edges k+1..k+4 and low when done=1.
- Back-to-back: start may be accepted in the done cycle.
REQ-015 result, ovf and inv SHALL hold their values until the next done pulse.
REQ-016 sub=1 SHALL invert b's sign bit before all further processing, including special cases.
REQ-017 In UNPACK, an operand with exp=0 (zero or subnormal) SHALL be treated as a signed zero (flush-to-zero); normal operands get the hidden bit 1.
REQ-018 In ALIGN:
- the smaller-magnitude significand SHALL be right-shifted by the exponent difference;
- guard, round and sticky bits SHALL be retained;
- shifts of 13 or more SHALL leave only the sticky bit.
REQ-019 In ADD, effective addition or subtraction SHALL be chosen from the signs; the result sign is the sign of the larger-magnitude operand.
REQ-020 In NORM:
- a carry-out SHALL be handled by a 1-bit right shift and exponent+1;
- leading zeros SHALL be removed by a single-cycle left shift (leading-zero count) with the matching exponent decrement.
REQ-021 In ROUND, rounding SHALL be round-to-nearest, ties-to-even; a rounding carry SHALL renormalise and increment the exponent.
REQ-022 Overflow handling:
- a final exponent of 31 or more SHALL give ±infinity (7C00/FC00) with ovf=1;
- a final exponent of 0 or less SHALL give signed zero with ovf=0.
REQ-023 An exact-zero result from operands of opposite effective sign SHALL be +0 (0000).
REQ-024 Special operands SHALL take priority over arithmetic:
- any NaN operand -> 7E00, inv=1;
- +inf plus -inf (effective) -> 7E00, inv=1;
- inf plus finite -> that inf, ovf=0, inv=0.
REQ-025 ovf and inv SHALL be 0 for every result not covered by REQ-022 or REQ-024.

Reset
REQ-026 While CLR=0, the block SHALL force state=IDLE, busy=0, done=0, result=0000, ovf=0 and inv=0, immediately and independent of CLK.
REQ-027 A CLR assertion in any non-IDLE state SHALL abort the operation with no done pulse; after CLR rises, the first start SHALL behave per REQ-014.

Verification
REQ-028 Basic add and latency: a=3C00, b=3C00, sub=0, start one cycle -> result=4000, ovf=0, inv=0, done exactly 5 edges after accept.
REQ-029 Cancellation and flush-to-zero:
- a=3C00, b=3C00, sub=1 -> 0000;
- a=3C00, b=0001 (subnormal) -> 3C00.
REQ-030 Tie rounding:
- 3C00+1000 -> 3C00 (tie, even kept);
- 3C01+1000 -> 3C02 (tie, round up to even).
REQ-031 Overflow and invalid:
- 7BFF+7BFF -> 7C00, ovf=1;
- 7C00 with sub=1 against 7C00 -> 7E00, inv=1;
- 7E00+3C00 -> 7E00, inv=1.
REQ-032 Busy and reset:
- start re-pulsed during busy is ignored (exactly one done);
- CLR pulsed low in ALIGN -> outputs zero at once, no done; a new start then gives a correct result.
